// File: rtl/display_digits_pkg.sv
// Shared segment encodings (active-low, {dp,g,f,e,d,c,b,a}) and timing helper
// for the multiplexed seven-segment display driver.
package display_digits_pkg;

   localparam int SEG_A  = 0;
   localparam int SEG_B  = 1;
   localparam int SEG_C  = 2;
   localparam int SEG_D  = 3;
   localparam int SEG_E  = 4;
   localparam int SEG_F  = 5;
   localparam int SEG_G  = 6;
   localparam int SEG_DP = 7;

   localparam logic [7:0] SEG_0     = 8'hC0;
   localparam logic [7:0] SEG_1     = 8'hF9;
   localparam logic [7:0] SEG_2     = 8'hA4;
   localparam logic [7:0] SEG_3     = 8'hB0;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h92;
   localparam logic [7:0] SEG_6     = 8'h82;
   localparam logic [7:0] SEG_7     = 8'hF8;
   localparam logic [7:0] SEG_8     = 8'h80;
   localparam logic [7:0] SEG_9     = 8'h90;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   // Cycles each digit stays lit; very slow clocks degrade to one cycle per digit.
   function automatic int digit_period(input int clk_hz, input int refresh_hz, input int n_digits);
      int p;
      p = clk_hz / (refresh_hz * n_digits);
      return (p < 1) ? 1 : p;
   endfunction

endpackage

// File: rtl/display_digits_decoder.sv
// BCD to active-low seven-segment decode; combinational, no backpressure.
// Non-decimal nibbles blank the digit and the decimal point is never lit.
module seven_seg_decoder (
   input  logic [3:0] digit,
   output logic [7:0] seg
);
   import display_digits_pkg::*;

   always_comb begin
      case (digit)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
      seg[SEG_DP] = 1'b1;
   end

endmodule

// File: rtl/display_digits.sv
// Time-multiplexed driver for up to four seven-segment digits; io_sel/io_seg are
// registered, one cycle after the digit index or number changes; no backpressure.
module display_digits #(
   parameter int NUMBER_OF_DIGITS            = 4,
   parameter int REFRESH_RATE_IN_HERTZ       = 1000,
   parameter int BOARD_CLOCK_FREQUENCY_IN_HZ = 100000000
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [4*NUMBER_OF_DIGITS-1:0] number,
   output logic [3:0]                    io_sel,
   output logic [7:0]                    io_seg
);
   import display_digits_pkg::*;

   localparam int DIGIT_PERIOD = digit_period(BOARD_CLOCK_FREQUENCY_IN_HZ,
                                              REFRESH_RATE_IN_HERTZ, NUMBER_OF_DIGITS);
   localparam int CNT_W = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGIT_PERIOD - 1);
   localparam logic [1:0]       IDX_LAST = 2'(NUMBER_OF_DIGITS - 1);

   logic [CNT_W-1:0] presc_q, presc_d;
   logic [1:0]       idx_q, idx_d;
   logic [3:0]       io_sel_q, io_sel_d;
   logic [7:0]       io_seg_q, io_seg_d;
   logic [3:0]       nibble;
   logic [7:0]       seg_dec;

   seven_seg_decoder u_dec (
      .digit (nibble),
      .seg   (seg_dec)
   );

   always_comb begin
      presc_d = presc_q + CNT_W'(1);
      idx_d   = idx_q;
      if (presc_q == CNT_LAST) begin
         presc_d = '0;
         idx_d   = (idx_q == IDX_LAST) ? 2'd0 : idx_q + 2'd1;
      end

      nibble = 4'd0;
      for (int k = 0; k < NUMBER_OF_DIGITS; k++) begin
         if (idx_q == 2'(k)) nibble = number[4*k +: 4];
      end

      // idx_q never reaches unused positions, so their enables stay high.
      io_sel_d        = 4'b1111;
      io_sel_d[idx_q] = 1'b0;
      io_seg_d        = seg_dec;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q  <= '0;
         idx_q    <= 2'd0;
         io_sel_q <= 4'b1111;
         io_seg_q <= SEG_BLANK;
      end else begin
         presc_q  <= presc_d;
         idx_q    <= idx_d;
         io_sel_q <= io_sel_d;
         io_seg_q <= io_seg_d;
      end
   end

   assign io_sel = io_sel_q;
   assign io_seg = io_seg_q;

endmodule

// File: tb/tb_display_digits.sv
// Bench for display_digits: a 3-digit instance with a 2-cycle digit period and a
// 4-digit instance whose digit period clamps to one cycle.
module tb_display_digits;

   logic        clk = 1'b0;
   logic        rst_a, rst_b;
   logic [11:0] number_a;
   logic [15:0] number_b;
   logic [3:0]  sel_a, sel_b;
   logic [7:0]  seg_a, seg_b;

   int total = 0;
   int bad   = 0;

   logic [11:0] exp_q[$];
   logic [7:0]  seg_tab[16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

   always #5 clk = ~clk;

   display_digits #(
      .NUMBER_OF_DIGITS            (3),
      .REFRESH_RATE_IN_HERTZ       (10),
      .BOARD_CLOCK_FREQUENCY_IN_HZ (60)
   ) dut_a (
      .clk    (clk),
      .rst    (rst_a),
      .number (number_a),
      .io_sel (sel_a),
      .io_seg (seg_a)
   );

   display_digits #(
      .NUMBER_OF_DIGITS            (4),
      .REFRESH_RATE_IN_HERTZ       (10),
      .BOARD_CLOCK_FREQUENCY_IN_HZ (10)
   ) dut_b (
      .clk    (clk),
      .rst    (rst_b),
      .number (number_b),
      .io_sel (sel_b),
      .io_seg (seg_b)
   );

   task automatic test_reset();
      logic [11:0] got, exp;
      rst_a    = 1'b1;
      number_a = 12'h000;
      for (int i = 0; i < 3; i++) exp_q.push_back({4'b1111, 8'hFF});
      exp_q.push_back({4'b1110, 8'hC0});
      for (int i = 0; i < 4; i++) begin
         if (i == 3) rst_a = 1'b0;
         @(posedge clk); #1;
         exp = exp_q.pop_front();
         got = {sel_a, seg_a};
         total++;
         if (got !== exp) begin
            bad++;
            $display("FAIL reset[%0d]: got sel=%b seg=%h, want sel=%b seg=%h",
                     i, got[11:8], got[7:0], exp[11:8], exp[7:0]);
         end
      end
   endtask

   task automatic test_sequence();
      logic [11:0] got, exp;
      logic [3:0]  sels[7] = '{4'b1110, 4'b1110, 4'b1101, 4'b1101, 4'b1011, 4'b1011, 4'b1110};
      logic [7:0]  segs[7] = '{8'h92, 8'h92, 8'h99, 8'h99, 8'hB0, 8'hB0, 8'h92};
      rst_a    = 1'b1;
      number_a = 12'h345;
      exp_q.push_back({4'b1111, 8'hFF});
      for (int i = 0; i < 7; i++) exp_q.push_back({sels[i], segs[i]});
      for (int i = 0; i < 8; i++) begin
         if (i == 1) rst_a = 1'b0;
         @(posedge clk); #1;
         exp = exp_q.pop_front();
         got = {sel_a, seg_a};
         total++;
         if (got !== exp) begin
            bad++;
            $display("FAIL sequence[%0d]: got sel=%b seg=%h, want sel=%b seg=%h",
                     i, got[11:8], got[7:0], exp[11:8], exp[7:0]);
         end
      end
   endtask

   task automatic test_decode_sweep();
      logic [11:0] got, exp;
      for (int v = 0; v < 16; v++) begin
         rst_a    = 1'b1;
         number_a = {8'h00, 4'(v)};
         exp_q.push_back({4'b1111, 8'hFF});
         exp_q.push_back({4'b1110, seg_tab[v]});
         for (int c = 0; c < 2; c++) begin
            if (c == 1) rst_a = 1'b0;
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            got = {sel_a, seg_a};
            total++;
            if (got !== exp) begin
               bad++;
               $display("FAIL decode[%0d.%0d]: got sel=%b seg=%h, want sel=%b seg=%h",
                        v, c, got[11:8], got[7:0], exp[11:8], exp[7:0]);
            end
            total++;
            if (seg_a[7] !== 1'b1) begin
               bad++;
               $display("FAIL dp_off[%0d.%0d]: got dp=%b, want 1", v, c, seg_a[7]);
            end
         end
      end
   endtask

   task automatic test_mid_change();
      logic [11:0] got, exp;
      logic [11:0] nums[4] = '{12'h001, 12'h001, 12'h007, 12'h007};
      rst_a = 1'b1;
      exp_q.push_back({4'b1111, 8'hFF});
      exp_q.push_back({4'b1110, 8'hF9});
      exp_q.push_back({4'b1110, 8'hF8});
      exp_q.push_back({4'b1101, 8'hC0});
      for (int i = 0; i < 4; i++) begin
         rst_a    = (i == 0);
         number_a = nums[i];
         @(posedge clk); #1;
         exp = exp_q.pop_front();
         got = {sel_a, seg_a};
         total++;
         if (got !== exp) begin
            bad++;
            $display("FAIL mid_change[%0d]: got sel=%b seg=%h, want sel=%b seg=%h",
                     i, got[11:8], got[7:0], exp[11:8], exp[7:0]);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [11:0] got, exp;
      logic        rsts[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      logic [11:0] exps[10] = '{{4'b1111, 8'hFF}, {4'b1110, 8'h92}, {4'b1110, 8'h92},
                                {4'b1101, 8'h99}, {4'b1101, 8'h99}, {4'b1011, 8'hB0},
                                {4'b1111, 8'hFF}, {4'b1110, 8'h92}, {4'b1110, 8'h92},
                                {4'b1101, 8'h99}};
      number_a = 12'h345;
      for (int i = 0; i < 10; i++) exp_q.push_back(exps[i]);
      for (int i = 0; i < 10; i++) begin
         rst_a = rsts[i];
         @(posedge clk); #1;
         exp = exp_q.pop_front();
         got = {sel_a, seg_a};
         total++;
         if (got !== exp) begin
            bad++;
            $display("FAIL reset_mid[%0d]: got sel=%b seg=%h, want sel=%b seg=%h",
                     i, got[11:8], got[7:0], exp[11:8], exp[7:0]);
         end
      end
   endtask

   task automatic test_variant_b();
      logic [11:0] got, exp;
      logic [11:0] exps[7] = '{{4'b1111, 8'hFF}, {4'b1110, 8'hF9}, {4'b1101, 8'hA4},
                               {4'b1011, 8'hB0}, {4'b0111, 8'h99}, {4'b1110, 8'hF9},
                               {4'b1101, 8'hA4}};
      rst_b    = 1'b1;
      number_b = 16'h4321;
      for (int i = 0; i < 7; i++) exp_q.push_back(exps[i]);
      for (int i = 0; i < 7; i++) begin
         if (i == 1) rst_b = 1'b0;
         @(posedge clk); #1;
         exp = exp_q.pop_front();
         got = {sel_b, seg_b};
         total++;
         if (got !== exp) begin
            bad++;
            $display("FAIL variant_b[%0d]: got sel=%b seg=%h, want sel=%b seg=%h",
                     i, got[11:8], got[7:0], exp[11:8], exp[7:0]);
         end
      end
   endtask

   initial begin
      rst_a    = 1'b1;
      rst_b    = 1'b1;
      number_a = 12'h000;
      number_b = 16'h0000;
      test_reset();
      test_sequence();
      test_decode_sweep();
      test_mid_change();
      test_reset_mid();
      test_variant_b();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/display_digits.md
DISPLAY_DIGITS -- requirements
Module: display_digits

Interface
REQ-001 Parameter NUMBER_OF_DIGITS, default 4, number of multiplexed digits in use; legal range 1..4.
REQ-002 Parameter REFRESH_RATE_IN_HERTZ, default 1000, full-frame rate (all digits shown once per frame).
REQ-003 Parameter BOARD_CLOCK_FREQUENCY_IN_HZ, default 100000000, frequency of clk.
REQ-004 The design SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  board clock; all state on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 number  input  4*NUMBER_OF_DIGITS  packed BCD digits; number[3:0] = digit 0 (least significant), number[4k+3:4k] = digit k.
REQ-008 io_sel  output  4  digit enables, active-low; io_sel[k] drives digit k.
REQ-009 io_seg  output  8  segment drives, active-low; bit order {dp,g,f,e,d,c,b,a} (bit 0 = a, bit 7 = dp).

Function
REQ-010 DIGIT_PERIOD SHALL be BOARD_CLOCK_FREQUENCY_IN_HZ / (REFRESH_RATE_IN_HERTZ * NUMBER_OF_DIGITS), integer-truncated, clamped to a minimum of 1.
REQ-011 A prescaler SHALL count 0..DIGIT_PERIOD-1 and wrap to 0; its counter width SHALL be derived via $clog2 of DIGIT_PERIOD (minimum 1 bit).
REQ-012 On the cycle the prescaler equals DIGIT_PERIOD-1, the digit index SHALL advance by 1, wrapping from NUMBER_OF_DIGITS-1 to 0.
REQ-013 io_sel and io_seg SHALL be registered: each rising edge (rst low) loads io_sel with index bit cleared and all other bits set, and io_seg with the decode of number nibble[index]; latency 1 cycle from index or number change.
REQ-014 Each digit SHALL therefore be enabled for exactly DIGIT_PERIOD consecutive cycles, in order 0,1,..,N-1,0...
REQ-015 io_sel bits at positions >= NUMBER_OF_DIGITS SHALL be held at 1 (off) at all times.
REQ-016 Exactly one io_sel bit SHALL be low at any time outside reset.
REQ-017 Decode (hex, active-low): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
REQ-018 Nibble values 10..15 SHALL decode to blank (FF).
REQ-019 Decimal point (io_seg[7]) SHALL always be 1 (off).
REQ-020 number is sampled continuously; a change mid-digit SHALL appear on io_seg on the next edge without waiting for the next digit slot.

Reset
REQ-021 While rst is high at a rising edge: prescaler=0, index=0, io_sel=4'b1111, io_seg=8'hFF.
REQ-022 Reset asserted mid-frame SHALL abort the current slot; the first edge after rst deasserts SHALL drive io_sel low on bit 0 with the digit-0 decode, and digit 0 SHALL be held a full DIGIT_PERIOD.

Structure
REQ-023 A shared package SHALL hold the ten segment constants, SEG_BLANK (8'hFF) and the {dp,g,f,e,d,c,b,a} bit-position constants.
REQ-024 One sub-module, seven_seg_decoder (4-bit in, 8-bit active-low out, combinational), SHALL implement REQ-017..REQ-019; display_digits SHALL contain the prescaler, index counter, nibble mux and output registers.

Verification (N=3, REFRESH=10, CLK=60 -> DIGIT_PERIOD=2)
REQ-025 Reset 3 cycles, number=12'h000 -> during reset io_sel=1111, io_seg=FF; first edge after release io_sel=1110, io_seg=C0.
REQ-026 number=12'h345 free-running -> io_sel sequence 1110,1110,1101,1101,1011,1011,1110... with io_seg 92,92,99,99,B0,B0,92; io_sel[3] always 1.
REQ-027 Sweep digit 0 through 0..15 -> io_seg matches REQ-017 for 0..9 and FF for 10..15; dp bit always 1.
REQ-028 Change number[3:0] from 1 to 7 during digit-0 slot first cycle -> second cycle of slot shows F8.
REQ-029 Assert rst while digit 2 is active -> outputs FF/1111 next edge; after release sequence restarts at digit 0 with full 2-cycle slot.
REQ-030 Parameter variant CLK=10, REFRESH=10, N=4 (DIGIT_PERIOD clamps to 1) -> index advances every cycle, all four io_sel bits used in turn.
